// File: rtl/dmem_mon_pkg.sv
// Shared types and encodings for the data-bus result monitor and its lane decoder.
package dmem_mon_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } mon_state_t;

    localparam logic [1:0]  SZ_BYTE    = 2'b00;
    localparam logic [1:0]  SZ_HALF    = 2'b01;
    localparam logic [1:0]  SZ_WORD    = 2'b10;

    localparam logic [31:0] DONE_MAGIC = 32'hDEAD_C0DE;

endpackage

// File: rtl/byte_lane_decode.sv
// Byte-enable decoder: access size + address offset -> SRAM lane enables, illegal flag.
// Zero-cycle combinational; no flow control.
module byte_lane_decode
    import dmem_mon_pkg::*;
(
    input  logic       req,
    input  logic [1:0] size,
    input  logic [1:0] offset,
    output logic [3:0] be,
    output logic       illegal
);

    logic [3:0] be_raw;

    always_comb begin
        be_raw = 4'b0000;
        case (size)
            SZ_BYTE: be_raw = 4'b0001 << offset;
            SZ_HALF: if (!offset[0]) be_raw = offset[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: if (offset == 2'b00) be_raw = 4'b1111;
            default: be_raw = 4'b0000;
        endcase
    end

    // Every legal access enables at least one lane, so an empty mask marks it illegal.
    assign be      = req ? be_raw : 4'b0000;
    assign illegal = req && (be_raw == 4'b0000);

endmodule

// File: rtl/dmem_result_monitor.sv
// Shadows result-window writes and checks them against EXP after a done-write or timeout.
// DBE is combinational; verdict appears NUM_SLOTS+1 cycles after the trigger edge; never stalls the bus.
module dmem_result_monitor
    import dmem_mon_pkg::*;
#(
    parameter int          NUM_SLOTS   = 16,
    parameter logic [31:0] RESULT_BASE = 32'h0000_0210,
    parameter logic [31:0] DONE_ADDR   = 32'h0000_03FC,
    parameter int          TIMEOUT_CYC = 9550
) (
    input  logic                             CLK,
    input  logic                             RESET_N,
    input  logic                             DREQ,
    input  logic [31:0]                      DADDR,
    input  logic                             DRW,
    input  logic [1:0]                       DSIZE,
    input  logic [31:0]                      DOUT,
    input  logic [32*NUM_SLOTS-1:0]          EXP,
    output logic [3:0]                       DBE,
    output logic                             DONE,
    output logic                             ALL_PASS,
    output logic [$clog2(NUM_SLOTS+1)-1:0]   PASS_CNT,
    output logic [NUM_SLOTS-1:0]             FAIL_MASK,
    output logic                             MISALIGN_ERR,
    output logic                             TIMEOUT_HIT
);

    localparam int          CNT_W     = $clog2(NUM_SLOTS + 1);
    localparam int          IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int          TMR_W     = $clog2(TIMEOUT_CYC);
    localparam logic [29:0] BASE_WORD = RESULT_BASE[31:2];

    mon_state_t        state;
    logic [TMR_W-1:0]  cyc_cnt;
    logic [IDX_W-1:0]  chk_idx;
    logic [31:0]       shadow [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] written;

    logic [3:0]        be;
    logic              illegal;
    logic [29:0]       word_off;
    logic              in_win;
    logic [IDX_W-1:0]  wr_slot;
    logic              slot_wr;
    logic              done_wr;
    logic              timeout;
    logic              slot_pass;

    byte_lane_decode u_lane_dec (
        .req     (DREQ),
        .size    (DSIZE),
        .offset  (DADDR[1:0]),
        .be      (be),
        .illegal (illegal)
    );

    assign DBE = be;

    assign word_off  = DADDR[31:2] - BASE_WORD;
    assign in_win    = (DADDR[31:2] >= BASE_WORD) && (word_off < 30'(NUM_SLOTS));
    assign wr_slot   = word_off[IDX_W-1:0];
    assign slot_wr   = (state == ST_RUN) && DREQ && DRW && !illegal && in_win;
    assign done_wr   = DREQ && DRW && (DSIZE == SZ_WORD) && (DADDR == DONE_ADDR)
                       && (DOUT == DONE_MAGIC);
    assign timeout   = (cyc_cnt == TMR_W'(TIMEOUT_CYC - 1));
    // An unwritten slot fails even if its expected value happens to be zero.
    assign slot_pass = written[chk_idx] && (shadow[chk_idx] == EXP[32*chk_idx +: 32]);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_SLOTS; i++) shadow[i] <= '0;
            written <= '0;
        end else if (slot_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) shadow[wr_slot][8*b +: 8] <= DOUT[8*b +: 8];
            end
            written[wr_slot] <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= ST_RUN;
            cyc_cnt      <= '0;
            chk_idx      <= '0;
            PASS_CNT     <= '0;
            FAIL_MASK    <= '0;
            DONE         <= 1'b0;
            ALL_PASS     <= 1'b0;
            MISALIGN_ERR <= 1'b0;
            TIMEOUT_HIT  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    cyc_cnt <= cyc_cnt + 1'b1;
                    if (illegal) MISALIGN_ERR <= 1'b1;
                    // A done-write in the timeout cycle takes credit for the trigger.
                    if (done_wr || timeout) begin
                        state       <= ST_CHECK;
                        chk_idx     <= '0;
                        TIMEOUT_HIT <= !done_wr;
                    end
                end
                ST_CHECK: begin
                    if (slot_pass) PASS_CNT <= PASS_CNT + 1'b1;
                    else           FAIL_MASK[chk_idx] <= 1'b1;
                    if (chk_idx == IDX_W'(NUM_SLOTS - 1)) state <= ST_DONE;
                    else                                  chk_idx <= chk_idx + 1'b1;
                end
                ST_DONE: begin
                    DONE     <= 1'b1;
                    ALL_PASS <= (PASS_CNT == CNT_W'(NUM_SLOTS));
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_result_monitor.sv
// Directed bench for dmem_result_monitor: lane decode, shadow/compare, done-write, timeout, mid-check reset.
module tb_dmem_result_monitor;

    localparam logic [31:0] MAGIC = 32'hDEAD_C0DE;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          DREQ;
    logic [31:0]   DADDR;
    logic          DRW;
    logic [1:0]    DSIZE;
    logic [31:0]   DOUT;
    logic [511:0]  EXP;
    logic [3:0]    DBE;
    logic          DONE;
    logic          ALL_PASS;
    logic [4:0]    PASS_CNT;
    logic [15:0]   FAIL_MASK;
    logic          MISALIGN_ERR;
    logic          TIMEOUT_HIT;

    int tests = 0;
    int fails = 0;
    int edge_no;
    int e;

    dmem_result_monitor dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .DREQ         (DREQ),
        .DADDR        (DADDR),
        .DRW          (DRW),
        .DSIZE        (DSIZE),
        .DOUT         (DOUT),
        .EXP          (EXP),
        .DBE          (DBE),
        .DONE         (DONE),
        .ALL_PASS     (ALL_PASS),
        .PASS_CNT     (PASS_CNT),
        .FAIL_MASK    (FAIL_MASK),
        .MISALIGN_ERR (MISALIGN_ERR),
        .TIMEOUT_HIT  (TIMEOUT_HIT)
    );

    always #5 CLK = ~CLK;

    // edge_no = n right after the n-th rising edge following reset release (first edge is 0).
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) edge_no <= -1;
        else          edge_no <= edge_no + 1;
    end

    function automatic logic [31:0] exp_val(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic rw, input logic [1:0] sz,
                       input logic [31:0] d, input logic [3:0] exp_be, input logic chk_be);
        @(negedge CLK);
        DREQ = 1'b1; DADDR = a; DRW = rw; DSIZE = sz; DOUT = d;
        #1;
        if (chk_be) chk($sformatf("dbe@%0h/sz%0d", a, sz), 32'(DBE), 32'(exp_be));
        @(posedge CLK);
        #1;
        DREQ = 1'b0; DRW = 1'b0;
    endtask

    task automatic wait_edge(input int n);
        while (edge_no < n) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_N = 1'b0; DREQ = 1'b0; DRW = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic write_all(input int skip);
        for (int i = 0; i < 16; i++) begin
            if (i != skip) bus(32'h210 + 32'(4*i), 1'b1, 2'b10, exp_val(i), 4'hF, 1'b0);
        end
    endtask

    initial begin
        RESET_N = 1'b0; DREQ = 1'b0; DADDR = '0; DRW = 1'b0; DSIZE = 2'b00; DOUT = '0;
        for (int i = 0; i < 16; i++) EXP[32*i +: 32] = exp_val(i);
        EXP[31:0]  = 32'h0000_0001;
        EXP[63:32] = 32'hFFFF_FFFD;

        #12;
        chk("rst_done",     32'(DONE),         32'd0);
        chk("rst_all_pass", 32'(ALL_PASS),     32'd0);
        chk("rst_pass_cnt", 32'(PASS_CNT),     32'd0);
        chk("rst_fail_mask",32'(FAIL_MASK),    32'd0);
        chk("rst_misalign", 32'(MISALIGN_ERR), 32'd0);
        chk("rst_timeout",  32'(TIMEOUT_HIT),  32'd0);
        chk("rst_dbe_idle", 32'(DBE),          32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Run 1: word + byte-lane writes, misaligned half, done-write.
        bus(32'h210, 1'b1, 2'b10, 32'h0000_0001, 4'b1111, 1'b1);
        bus(32'h214, 1'b1, 2'b00, 32'h0000_00FD, 4'b0001, 1'b1);
        bus(32'h215, 1'b1, 2'b00, 32'h0000_FF00, 4'b0010, 1'b1);
        bus(32'h216, 1'b1, 2'b00, 32'h00FF_0000, 4'b0100, 1'b1);
        bus(32'h217, 1'b1, 2'b00, 32'hFF00_0000, 4'b1000, 1'b1);
        bus(32'h212, 1'b0, 2'b01, 32'h0,         4'b1100, 1'b1);
        bus(32'h210, 1'b0, 2'b01, 32'h0,         4'b0011, 1'b1);
        chk("misalign_before", 32'(MISALIGN_ERR), 32'd0);
        bus(32'h211, 1'b1, 2'b01, 32'hFFFF_FFFF, 4'b0000, 1'b1);
        chk("misalign_half_odd", 32'(MISALIGN_ERR), 32'd1);
        bus(32'h3FC, 1'b1, 2'b10, MAGIC, 4'b1111, 1'b1);
        e = edge_no;
        wait_edge(e + 16);
        chk("r1_done_at_16", 32'(DONE), 32'd0);
        wait_edge(e + 17);
        chk("r1_done_at_17",  32'(DONE),        32'd1);
        chk("r1_fail_mask",   32'(FAIL_MASK),   32'h0000_FFFC);
        chk("r1_pass_cnt",    32'(PASS_CNT),    32'd2);
        chk("r1_all_pass",    32'(ALL_PASS),    32'd0);
        chk("r1_timeout_hit", 32'(TIMEOUT_HIT), 32'd0);

        // Run 2: slot 5 never written while its expected value is zero.
        do_reset();
        for (int i = 0; i < 16; i++) EXP[32*i +: 32] = exp_val(i);
        EXP[32*5 +: 32] = 32'h0;
        write_all(5);
        bus(32'h3FC, 1'b1, 2'b10, MAGIC, 4'b1111, 1'b0);
        e = edge_no;
        wait_edge(e + 17);
        chk("r2_done",      32'(DONE),         32'd1);
        chk("r2_fail_mask", 32'(FAIL_MASK),    32'h0000_0020);
        chk("r2_pass_cnt",  32'(PASS_CNT),     32'd15);
        chk("r2_all_pass",  32'(ALL_PASS),     32'd0);
        bus(32'h211, 1'b1, 2'b01, 32'h0, 4'b0000, 1'b1);
        chk("r2_misalign_ignored_in_done", 32'(MISALIGN_ERR), 32'd0);

        // Run 3: reset while checking slot 7, then a run that only ends by timeout.
        do_reset();
        EXP[32*5 +: 32] = exp_val(5);
        write_all(-1);
        bus(32'h300, 1'b0, 2'b11, 32'h0, 4'b0000, 1'b1);
        chk("r3_misalign_dsize11", 32'(MISALIGN_ERR), 32'd1);
        bus(32'h3FC, 1'b1, 2'b10, MAGIC, 4'b1111, 1'b0);
        e = edge_no;
        wait_edge(e + 7);
        chk("r3_partial_pass_cnt", 32'(PASS_CNT), 32'd7);
        RESET_N = 1'b0;
        #1;
        chk("r3_rst_pass_cnt",  32'(PASS_CNT),     32'd0);
        chk("r3_rst_fail_mask", 32'(FAIL_MASK),    32'd0);
        chk("r3_rst_misalign",  32'(MISALIGN_ERR), 32'd0);
        chk("r3_rst_done",      32'(DONE),         32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        write_all(-1);
        bus(32'h3FC, 1'b1, 2'b10, 32'h1234_5678, 4'b1111, 1'b0);
        e = edge_no;
        wait_edge(e + 17);
        chk("r4_bad_magic_no_done", 32'(DONE), 32'd0);
        wait_edge(9565);
        chk("r4_done_at_9565", 32'(DONE), 32'd0);
        wait_edge(9566);
        chk("r4_done_at_9566", 32'(DONE),        32'd1);
        chk("r4_timeout_hit",  32'(TIMEOUT_HIT), 32'd1);
        chk("r4_all_pass",     32'(ALL_PASS),    32'd1);
        chk("r4_pass_cnt",     32'(PASS_CNT),    32'd16);
        chk("r4_fail_mask",    32'(FAIL_MASK),   32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_result_monitor.md
# dmem_result_monitor

Synthesizable, parametrised data-bus result monitor sitting beside the CortexM0 data port and the SRAM.
- Generates the SRAM byte enables from the core's access size and address offset.
- Shadows every write that lands in a result window and, at a timeout or on a software done-write, compares each slot against a supplied expected value.
- Reports pass count, per-slot fail mask and alignment errors in hardware, replacing fixed-cycle file dumps.

## Interface

Parameters:
- NUM_SLOTS, 16, number of 32-bit result words checked (1..64)
- RESULT_BASE, 32'h0000_0210, byte address of slot 0 (word aligned)
- DONE_ADDR, 32'h0000_03FC, word address whose magic write ends the run
- TIMEOUT_CYC, 9550, cycles after reset release before forced check (≥2)

Ports:
- CLK  in  1  clock, rising edge. Single clock domain.
- RESET_N  in  1  asynchronous, active-low reset
- DREQ  in  1  data access valid this cycle
- DADDR  in  32  data byte address
- DRW  in  1  1 = write, 0 = read
- DSIZE  in  2  00 byte, 01 half, 10 word, 11 illegal
- DOUT  in  32  core write data
- EXP  in  32*NUM_SLOTS  expected values; slot i occupies [32i+31:32i]; must be static during CHECK
- DBE  out  4  SRAM byte enables (combinational)
- DONE  out  1  check complete; sticky until reset
- ALL_PASS  out  1  DONE and every slot passed
- PASS_CNT  out  clog2(NUM_SLOTS+1)  passing slots
- FAIL_MASK  out  NUM_SLOTS  bit i set = slot i failed
- MISALIGN_ERR  out  1  sticky: illegal/misaligned access seen
- TIMEOUT_HIT  out  1  check entered through timeout, not done-write

## Operation

- DBE, from {DSIZE, DADDR[1:0]}, only when DREQ=1, else 4'b0000:
  - byte: 0001 / 0010 / 0100 / 1000 for offsets 0..3
  - half: 0011 at offset 0, 1100 at offset 2
  - word: 1111 at offset 0
  - every other combination gives 0000 and sets MISALIGN_ERR (read or write) while in RUN.
- Shadow update, in RUN only:
  - condition: DREQ & DRW, legal DBE, DADDR[31:2] within [RESULT_BASE>>2, (RESULT_BASE>>2)+NUM_SLOTS).
  - slot = word offset; enabled byte lanes of DOUT merged into the shadow; slot's written bit set.
- Done-write: DREQ & DRW & DSIZE=10 & DADDR==DONE_ADDR & DOUT==32'hDEAD_C0DE. Any other value at DONE_ADDR is ignored.
- States:
  - RUN: entered at reset release. Cycle counter increments each cycle.
  - RUN→CHECK: counter==TIMEOUT_CYC-1 (sets TIMEOUT_HIT) or done-write, whichever comes first. If both occur in the same cycle, TIMEOUT_HIT=0.
  - CHECK: index k = 0..NUM_SLOTS-1, one slot per cycle. Pass = written[k] & shadow[k]==EXP[k]; otherwise FAIL_MASK[k] set. PASS_CNT increments on pass.
  - CHECK→DONE: after slot NUM_SLOTS-1 is evaluated.
  - DONE: terminal. ALL_PASS = (PASS_CNT==NUM_SLOTS). All bus activity is ignored for shadow updates and MISALIGN_ERR; DBE still decodes.
- Unwritten slot always fails, even when EXP is 0.
- Reads, out-of-window writes and writes during CHECK/DONE do not alter shadows.

## Timing

- Reset values: DONE=0, ALL_PASS=0, PASS_CNT=0, FAIL_MASK=0, MISALIGN_ERR=0, TIMEOUT_HIT=0. Shadows, written bits, counter and index all 0; state RUN.
- Asynchronous assert clears all state immediately. Release is sampled on the next CLK edge.
- DBE: zero-cycle combinational latency.
- Shadow: updated at the edge sampling the write; visible to CHECK from the next cycle.
- A done-write to the last slot and DONE_ADDR can never coincide; a slot write in the done-write cycle is not possible (one access per cycle).
- Latency from the trigger edge to DONE=1: NUM_SLOTS+1 cycles. PASS_CNT/FAIL_MASK are final in the same cycle DONE rises.
- Timeout: with no done-write, DONE rises at cycle TIMEOUT_CYC+NUM_SLOTS after release.
- Reset mid-CHECK: partial PASS_CNT/FAIL_MASK discarded; a new run begins.

## Structure

- Package dmem_mon_pkg:
  - state enum {RUN, CHECK, DONE}
  - DSIZE encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - DONE_MAGIC = 32'hDEAD_C0DE
- Sub-module byte_lane_decode: DSIZE, DADDR[1:0], DREQ → DBE, illegal flag. Purely combinational; reusable by the SRAM wrapper.
- Top holds the shadow array, written mask, cycle counter, check index and FSM.

## Test plan

- Word write 32'h0000_0001 to 0x210, EXP[0]=1, done-write → FAIL_MASK bit0=0, DONE after 17 cycles.
- Byte writes 0xFD,0xFF,0xFF,0xFF to 0x214..0x217, EXP[1]=32'hFFFF_FFFD → slot1 passes. Check DBE 0001/0010/0100/1000.
- Half write at offset 01 (DADDR=0x211) → DBE=0000, MISALIGN_ERR=1, shadow0 unchanged. DSIZE=11 also flags.
- All 16 slots written to match EXP, no done-write → TIMEOUT_HIT=1, ALL_PASS=1, PASS_CNT=16 at cycle 9566.
- Slot 5 never written, EXP[5]=0 → FAIL_MASK=16'h0020, PASS_CNT=15, ALL_PASS=0.
- RESET_N low during CHECK at k=7 → all outputs 0 immediately. Rerun with a done-write value of 32'h1234_5678 → no trigger until timeout.
